pa_feed: RTL

PA_FEED -- requirements
Module: pa_feed

---
 rtl/pa_feed_pkg.sv | 14 +
 rtl/pa_fifo.sv | 59 +++++
 rtl/pa_feed.sv | 109 ++++++++++
 3 files changed

// File: rtl/pa_feed_pkg.sv
// Shared definitions for the PA feed path: sequencer state codes (also the
// datapath config-RAM addresses) and default sizing.
package pa_feed_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_COPY = 3'b001,
    ST_WAIT = 3'b010
  } state_t;

endpackage

// File: rtl/pa_fifo.sv
// Word queue for the PA feed: power-of-two ring buffer with occupancy count.
// Push is ignored when full and pop is ignored when empty.
module pa_fifo
  import pa_feed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/pa_feed.sv
// PA feed sequencer: moves queued words to the datapath parallel input one at
// a time and raises a word-ready interrupt until the CPU acknowledges.
//
//   state | meaning
//   IDLE  | waiting for a queued word; pi holds the last word
//   COPY  | pi just loaded from the queue head (one cycle)
//   WAIT  | isr high, waiting for isr_ack
module pa_feed
  import pa_feed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     isr_ack,
  output logic [DATA_W-1:0]        pi,
  output logic [2:0]               cs_addr,
  output logic                     isr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               words_out
);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  state_t            r_state;
  logic [DATA_W-1:0] r_pi;
  logic              r_isr;
  logic [7:0]        r_words;
  logic              r_avail;

  // Assertion is immediate; release ripples through two flops. The queue
  // accepts words once the first stage is high, the sequencer one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];
  assign w_push  = in_valid & r_rst_sync[0];
  assign w_pop   = (r_state == ST_IDLE) & r_avail;

  pa_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clock (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // r_avail lags occupancy by one cycle; safe because only this FSM pops and
  // it is never back in IDLE sooner than two edges after a pop.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_pi    <= '0;
      r_isr   <= 1'b0;
      r_words <= 8'd0;
      r_avail <= 1'b0;
    end else begin
      r_avail <= ~w_empty;
      case (r_state)
        ST_IDLE: begin
          if (r_avail) begin
            r_state <= ST_COPY;
            r_pi    <= w_head;
          end
        end
        ST_COPY: begin
          r_state <= ST_WAIT;
          r_isr   <= 1'b1;
          r_words <= r_words + 8'd1;
        end
        ST_WAIT: begin
          if (isr_ack) begin
            r_state <= ST_IDLE;
            r_isr   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_isr   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~w_full;
  assign pi        = r_pi;
  assign cs_addr   = r_state;
  assign isr       = r_isr;
  assign words_out = r_words;

endmodule
